// File: rtl/mdu32_if.sv
// Request/response bundle between the decoder/fetch side and the multiply/divide unit.
// The master drives the operation and MT writes; the slave returns HI/LO and status.
interface mdu32_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   modport master (output start, op, operand_a, operand_b, mthi_we, mtlo_we, wdata,
                   input  hi, lo, busy, done);
   modport slave  (input  start, op, operand_a, operand_b, mthi_we, mtlo_we, wdata,
                   output hi, lo, busy, done);
endinterface

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit with HI/LO: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fix-up in a final cycle.
module mdu32 (
   input  logic   clock,
   input  logic   reset,
   mdu32_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [1:0]  op_q;
   logic        sign_a_q, sign_b_q, divz_q, done_q;
   logic [31:0] a_orig_q, b_q, rem_q, hi_q, lo_q;
   logic [63:0] acc_q;

   // Launch-time operand conditioning (op[0]=0 selects the signed variants)
   logic        sa_d, sb_d;
   logic [31:0] mag_a_d, mag_b_d;
   assign sa_d    = ~bus.op[0] & bus.operand_a[31];
   assign sb_d    = ~bus.op[0] & bus.operand_b[31];
   assign mag_a_d = sa_d ? -bus.operand_a : bus.operand_a;
   assign mag_b_d = sb_d ? -bus.operand_b : bus.operand_b;

   // Multiply step: acc[63:32] accumulates, acc[31:0] shifts out multiplier bits
   logic [32:0] mul_sum_d;
   assign mul_sum_d = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};

   // Divide step: acc[31:0] shifts dividend out and quotient in
   logic [32:0] shifted_d, diff_d;
   logic        qbit_d;
   logic [31:0] rem_d;
   assign shifted_d = {rem_q, acc_q[31]};
   assign diff_d    = shifted_d - {1'b0, b_q};
   assign qbit_d    = ~diff_d[32];
   assign rem_d     = qbit_d ? diff_d[31:0] : shifted_d[31:0];

   logic [63:0] acc_d;
   assign acc_d = op_q[1] ? {acc_q[63:32], acc_q[30:0], qbit_d}
                          : {mul_sum_d, acc_q[31:1]};

   // Sign correction for writeback
   logic        neg_res;
   logic [63:0] prod_d;
   logic [31:0] quot_d, remf_d, hi_fix_d, lo_fix_d;
   assign neg_res = sign_a_q ^ sign_b_q;
   assign prod_d  = (op_q == 2'b00 && neg_res) ? -acc_q : acc_q;
   assign quot_d  = (op_q == 2'b10 && neg_res) ? -acc_q[31:0] : acc_q[31:0];
   assign remf_d  = (op_q == 2'b10 && sign_a_q) ? -rem_q : rem_q;

   always_comb begin
      hi_fix_d = prod_d[63:32];
      lo_fix_d = prod_d[31:0];
      if (op_q[1]) begin
         hi_fix_d = divz_q ? a_orig_q : remf_d;
         lo_fix_d = divz_q ? 32'hFFFF_FFFF : quot_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         op_q     <= 2'b00;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         divz_q   <= 1'b0;
         done_q   <= 1'b0;
         a_orig_q <= 32'd0;
         b_q      <= 32'd0;
         rem_q    <= 32'd0;
         acc_q    <= 64'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.mthi_we) hi_q <= bus.wdata;
               if (bus.mtlo_we) lo_q <= bus.wdata;
               if (bus.start) begin
                  op_q     <= bus.op;
                  sign_a_q <= sa_d;
                  sign_b_q <= sb_d;
                  divz_q   <= bus.op[1] & (bus.operand_b == 32'd0);
                  a_orig_q <= bus.operand_a;
                  b_q      <= mag_b_d;
                  acc_q    <= {32'd0, mag_a_d};
                  rem_q    <= 32'd0;
                  cnt_q    <= 5'd0;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               if (op_q[1]) rem_q <= rem_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_fix_d;
               lo_q    <= lo_fix_d;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
endmodule

// File: doc/mdu32.md
# mdu32

Iterative 32-bit multiply/divide unit with HI/LO registers for the Minisys single-cycle core. It executes MULT, MULTU, DIV and DIVU, and serves MFHI/MFLO/MTHI/MTLO. It sits directly downstream of the instruction decoder and takes its two register read ports (rs, rt) as operands. While an operation is in flight it raises `busy`, which the fetch unit uses to stall PC.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch the operation selected by `op`; sampled only in IDLE.
- `op`  in  2  operation, equal to funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  32  rs value (decoder read_data_1).
- `operand_b`  in  32  rt value (decoder read_data_2).
- `mthi_we`  in  1  write `wdata` to HI (MTHI).
- `mtlo_we`  in  1  write `wdata` to LO (MTLO).
- `wdata`  in  32  MTHI/MTLO data (rs value).
- `hi`  out  32  HI register (MFHI source), registered.
- `lo`  out  32  LO register (MFLO source), registered.
- `busy`  out  1  operation in flight; stall request.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - FIX: sign correction and HI/LO writeback.
- Transitions:
  - IDLE -> CALC when `start`=1; latches `op`, the operands and the sign flags.
  - CALC -> FIX when the counter reaches 31.
  - FIX -> IDLE unconditionally.
- Operand conditioning:
  - Signed ops (MULT, DIV) take two's-complement magnitudes of negative operands and record the sign flags.
  - Unsigned ops use the operands as-is.
- Multiply: radix-2 shift-add, one multiplier bit per CALC cycle, into a 64-bit accumulator.
  - MULT: the product is negated in FIX if sign_a XOR sign_b.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division, one quotient bit per cycle, 33-bit partial remainder.
  - LO = quotient, HI = remainder.
  - DIV: quotient is negated if sign_a XOR sign_b; remainder takes the sign of the dividend.
- Divide by zero (`operand_b`=0, DIV or DIVU):
  - Normal latency.
  - Result is LO=32'hFFFFFFFF, HI=`operand_a` (unconditioned original value).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. Magnitude arithmetic wraps naturally; no trap.
- MTHI/MTLO:
  - Write HI or LO at the clock edge, but only in IDLE.
  - Ignored while `busy`=1; software must not issue them during an operation.
- `start` together with `mthi_we`/`mtlo_we` in IDLE: the MT write occurs and the operation launches. The later FIX writeback overwrites both HI and LO.
- `start` while `busy`=1 is ignored; no queuing.
- `op` and the operands are captured at launch. Later changes on the input ports have no effect.

## Timing
- Reset values: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- Reset asserted mid-operation aborts the operation immediately at that edge, with all reset values applied. No writeback occurs.
- Edge E0: `start` sampled in IDLE.
- `busy` is high in the cycles following E0 through E33, i.e. 33 cycles. It is a combinational decode of state != IDLE.
- E1..E32: CALC iterations.
- E33: FIX writeback. `hi`/`lo` show the new result after E33, and `done`=1 for exactly that one cycle.
- Back-to-back: `start` may be asserted in the cycle where `done`=1 (state is IDLE). That is the next E0, so throughput is one operation per 34 cycles.
- MFHI/MFLO: `hi`/`lo` are plain register outputs with no read latency. Values read while `busy`=1 are the old values.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after E33 HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once; `busy` high for exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234 after normal latency.
- MTHI 0xAAAA5555 and MTLO 0x5555AAAA in IDLE -> `hi`/`lo` updated next cycle. Then start a MULT; MTLO 0x1 and a second `start` issued during busy -> both ignored; final HI/LO equal the first MULT result.
- Reset asserted at CALC iteration 10 of a DIV -> next cycle `busy`=0, `done`=0, `hi`=`lo`=0; no `done` pulse follows; a fresh MULTU 6×7 then gives LO=42, HI=0.
